mul_issue_pipe: RTL and testbench
=================================

// Module: mul_issue_pipe
// PURPOSE
// Consumer side of the multiplier reservation station. Each cycle it picks one
// ready RS entry, asserts clearbusy/issueaddr, and captures the operands the RS
// returns combinationally. It runs a fixed-latency pipelined 32x32 multiply and
// broadcasts the result on one exrslt/exdst/kill_spec forwarding port.
// Every RS src_manager snoops that port. Both the pipeline and the picker obey
// branch-miss kill and branch-success spec clearing.
// PARAMETERS
// DATA_LEN     32  operand/result width
// RRF_SEL      6   rename-register tag width
// SPECTAG_LEN  5   speculative tag width (one-hot)
// ENT_NUM      2   RS entries
// ENT_SEL      1   clog2(ENT_NUM)
// LAT          3   issue-to-result latency in cycles, >=2
// PORTS
// clk          in   1            clock, rising edge
// reset        in   1            asynchronous, active-low reset (0 = reset)
// prmiss       in   1            branch mispredict resolved this cycle
// prsuccess    in   1            branch prediction confirmed this cycle
// prtag        in   SPECTAG_LEN  tag of branch resolved by prsuccess
// specfixtag   in   SPECTAG_LEN  mask of tags squashed on prmiss
// ready        in   ENT_NUM      per-entry ready (busy & both operands valid)
// issueaddr    out  ENT_SEL      entry selected (read address into RS)
// clearbusy    out  1            issue fire: RS clears busyvec[issueaddr]
// ex_src1/2    in   DATA_LEN     operands of entry issueaddr (same cycle)
// rrftag       in   RRF_SEL      destination tag of entry issueaddr
// dstval       in   1            entry writes a register
// spectag      in   SPECTAG_LEN  entry speculative tag
// specbit      in   1            entry is speculative
// src1_signed  in   1            treat src1 as signed
// src2_signed  in   1            treat src2 as signed
// sel_lohi     in   1            1 = return upper DATA_LEN bits, 0 = lower
// exrslt       out  DATA_LEN     broadcast result
// exdst        out  RRF_SEL      broadcast destination tag
// kill_spec    out  1            1 = broadcast invalid; snoopers ignore it
// rob_we       out  1            valid completion this cycle
// rrf_we       out  1            rob_we & dstval of completing op
// BEHAVIOUR
// - Reset (reset==0, async): all stage valids 0, rr pointer 0. Outputs:
//   exrslt 0, exdst 0, kill_spec 1, rob_we 0, rrf_we 0.
// - Pick: round-robin. Search starts at entry rrptr+1 mod ENT_NUM; first set
//   ready bit wins. issueaddr is combinational and equals the winner, or rrptr
//   when none is ready. clearbusy = |ready & ~prmiss. rrptr <= issueaddr on fire.
// - No issue while prmiss=1. Issue is allowed during prsuccess; the RS-supplied
//   specbit is already updated, so it is captured as-is. The pipeline never
//   stalls: one issue per cycle max.
// - Fire at cycle C latches into stage 1: operands, rrftag, dstval, spectag,
//   specbit, signed flags, sel_lohi.
// - Arithmetic: extend each operand to DATA_LEN+1 bits (sign if *_signed, else
//   zero). Form the 2*DATA_LEN+2-bit signed product and take bits [DATA_LEN-1:0]
//   (lo) or [2*DATA_LEN-1:DATA_LEN] (hi). The multiply may be split across
//   stages 1..LAT-1; latency is exactly LAT.
// - Result for fire at C is registered on the outputs in cycle C+LAT:
//   kill_spec 0, rob_we 1, rrf_we = dstval, exdst = rrftag.
//   Empty output slot: kill_spec 1, rob_we 0, rrf_we 0, exrslt/exdst 0.
// - prmiss: every in-flight stage (including the output register about to load)
//   with specbit=1 and (spectag & specfixtag)!=0 clears its valid at the edge.
//   Non-matching stages continue unchanged.
// - prsuccess: every stage with spectag==prtag clears specbit at the edge.
// - prmiss and prsuccess are never asserted together. If they are, prmiss wins.
// - reset deasserted mid-flight: all in-flight ops are lost; no spurious output.
// TESTING
// - src1=-3,src2=5, both signed, lo, issue at C
//     -> C+3: exrslt=0xFFFFFFF1, exdst=tag, rob_we=1, kill_spec=0.
// - 0xFFFFFFFF*0xFFFFFFFF unsigned hi -> 0xFFFFFFFE.
//   Same operands, signed hi -> 0x00000000. src1 signed, src2 unsigned, hi
//   -> 0xFFFFFFFF.
// - ready=2'b11 held 4 cycles
//     -> issueaddr alternates 1,0,1,0; clearbusy=1 each cycle; 4 results
//        back-to-back from C+3.
// - Op tag 5'b00010 (specbit=1) in stage 2, prmiss with specfixtag=5'b00110
//     -> no output; a same-time op with tag 5'b01000 completes.
//   prmiss with ready=2'b01 -> clearbusy=0.
// - prsuccess prtag=5'b00010 while op in flight, then prmiss specfixtag=5'b00010
//   -> op survives and completes.
// - reset pulled low for 1 cycle with 3 ops in flight
//     -> outputs take reset values at once; no rob_we afterwards.

Source files
------------

// File: rtl/mul_issue_pipe.sv
// mul_issue_pipe
//   Consumer side of the multiplier reservation station. Each cycle a
//   round-robin picker selects one ready RS entry. On a fire it asserts
//   clearbusy/issueaddr and captures the operands that the RS returns
//   combinationally. The op then runs through a fixed-latency pipelined
//   multiply. The result is broadcast on a single exrslt/exdst/kill_spec
//   forwarding port. Both the picker and the pipeline honour branch-miss
//   kill (prmiss/specfixtag) and branch-success spec clearing
//   (prsuccess/prtag).
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   prmiss, specfixtag          mispredict and the mask of squashed tags
//   prsuccess, prtag            confirmed branch and its tag
//   ready                       per-entry ready vector from the RS
//   issueaddr, clearbusy        selected entry / issue fire back to the RS
//   ex_src1, ex_src2, rrftag,   payload of entry issueaddr, same cycle
//   dstval, spectag, specbit,
//   src1_signed, src2_signed,
//   sel_lohi
//   exrslt, exdst, kill_spec    forwarding broadcast (kill_spec=1 means invalid)
//   rob_we, rrf_we              completion strobes
module mul_issue_pipe #(
    parameter int DATA_LEN    = 32,
    parameter int RRF_SEL     = 6,
    parameter int SPECTAG_LEN = 5,
    parameter int ENT_NUM     = 2,
    parameter int ENT_SEL     = 1,
    parameter int LAT         = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] prtag,
    input  logic [SPECTAG_LEN-1:0] specfixtag,
    input  logic [ENT_NUM-1:0]     ready,
    output logic [ENT_SEL-1:0]     issueaddr,
    output logic                   clearbusy,
    input  logic [DATA_LEN-1:0]    ex_src1,
    input  logic [DATA_LEN-1:0]    ex_src2,
    input  logic [RRF_SEL-1:0]     rrftag,
    input  logic                   dstval,
    input  logic [SPECTAG_LEN-1:0] spectag,
    input  logic                   specbit,
    input  logic                   src1_signed,
    input  logic                   src2_signed,
    input  logic                   sel_lohi,
    output logic [DATA_LEN-1:0]    exrslt,
    output logic [RRF_SEL-1:0]     exdst,
    output logic                   kill_spec,
    output logic                   rob_we,
    output logic                   rrf_we
);

    // Stages 1..LAT-1 live at indices 0..NST-1; the output register is stage LAT.
    localparam int NST = LAT - 1;

    // ---------------- round-robin picker ----------------
    logic [ENT_SEL-1:0] rrptr_reg;
    logic [ENT_SEL-1:0] pick;
    logic [ENT_SEL-1:0] cand;

    // Walk the candidates from farthest to nearest so that the nearest ready
    // entry after rrptr is the last assignment and therefore wins.
    always_comb begin
        pick = rrptr_reg;
        cand = '0;
        for (int i = ENT_NUM; i >= 1; i--) begin
            cand = ENT_SEL'((int'(rrptr_reg) + i) % ENT_NUM);
            if (ready[cand]) begin
                pick = cand;
            end
        end
    end

    assign issueaddr = pick;
    assign clearbusy = (|ready) & ~prmiss;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrptr_reg <= '0;
        end else if (clearbusy) begin
            rrptr_reg <= pick;
        end
    end

    // ---------------- pipeline control ----------------
    logic [NST-1:0]         v_reg;
    logic [NST-1:0]         sb_reg;
    logic [NST-1:0]         dv_reg;
    logic [SPECTAG_LEN-1:0] st_reg  [NST];
    logic [RRF_SEL-1:0]     tag_reg [NST];
    logic [DATA_LEN:0]      a_reg;
    logic [DATA_LEN:0]      b_reg;
    logic                   lohi_reg;
    logic [NST-1:0]         kill;

    // An op is squashed as it leaves its stage, so the kill decision is made
    // on the stage feeding each register (including the output register).
    genvar gi;
    generate
        for (gi = 0; gi < NST; gi++) begin : g_kill
            assign kill[gi] = prmiss & sb_reg[gi] & (|(st_reg[gi] & specfixtag));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_reg    <= '0;
            sb_reg   <= '0;
            dv_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            lohi_reg <= 1'b0;
            for (int k = 0; k < NST; k++) begin
                st_reg[k]  <= '0;
                tag_reg[k] <= '0;
            end
        end else begin
            // Stage 1: the RS has already applied any same-cycle prsuccess
            // to specbit, so it is taken as-is.
            v_reg[0] <= clearbusy;
            if (clearbusy) begin
                a_reg      <= {src1_signed & ex_src1[DATA_LEN-1], ex_src1};
                b_reg      <= {src2_signed & ex_src2[DATA_LEN-1], ex_src2};
                lohi_reg   <= sel_lohi;
                sb_reg[0]  <= specbit;
                st_reg[0]  <= spectag;
                tag_reg[0] <= rrftag;
                dv_reg[0]  <= dstval;
            end
            for (int k = 1; k < NST; k++) begin
                v_reg[k]   <= v_reg[k-1] & ~kill[k-1];
                // prmiss has priority: spec clearing only applies without it.
                sb_reg[k]  <= sb_reg[k-1] &
                              ~(~prmiss & prsuccess & (st_reg[k-1] == prtag));
                st_reg[k]  <= st_reg[k-1];
                tag_reg[k] <= tag_reg[k-1];
                dv_reg[k]  <= dv_reg[k-1];
            end
        end
    end

    // ---------------- multiply datapath ----------------
    // The top two bits of the (2N+2)-bit product are never selected, so a
    // 2N-bit product of the sign-extended (N+1)-bit operands gives the same
    // low and high words.
    logic [2*DATA_LEN-1:0] prod;
    logic [DATA_LEN-1:0]   mul_sel;
    logic [DATA_LEN-1:0]   stage_res [NST];

    assign prod    = {{(DATA_LEN-1){a_reg[DATA_LEN]}}, a_reg} *
                     {{(DATA_LEN-1){b_reg[DATA_LEN]}}, b_reg};
    assign mul_sel = lohi_reg ? prod[2*DATA_LEN-1:DATA_LEN] : prod[DATA_LEN-1:0];

    // Stage 1 holds operands; its result is the combinational multiply.
    // Later stages simply carry the selected word.
    generate
        for (gi = 0; gi < NST; gi++) begin : g_res
            if (gi == 0) begin : g_first
                assign stage_res[gi] = mul_sel;
            end else begin : g_pipe
                logic [DATA_LEN-1:0] res_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        res_reg <= '0;
                    end else begin
                        res_reg <= stage_res[gi-1];
                    end
                end
                assign stage_res[gi] = res_reg;
            end
        end
    endgenerate

    // ---------------- output register ----------------
    logic out_v_reg;
    logic out_dv_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_v_reg  <= 1'b0;
            out_dv_reg <= 1'b0;
            exrslt     <= '0;
            exdst      <= '0;
        end else begin
            out_v_reg  <= v_reg[NST-1] & ~kill[NST-1];
            out_dv_reg <= dv_reg[NST-1];
            if (v_reg[NST-1] & ~kill[NST-1]) begin
                exrslt <= stage_res[NST-1];
                exdst  <= tag_reg[NST-1];
            end else begin
                exrslt <= '0;
                exdst  <= '0;
            end
        end
    end

    assign kill_spec = ~out_v_reg;
    assign rob_we    = out_v_reg;
    assign rrf_we    = out_v_reg & out_dv_reg;

endmodule

// File: tb/tb_mul_issue_pipe.sv
module tb_mul_issue_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prmiss = 1'b0;
    logic        prsuccess = 1'b0;
    logic [4:0]  prtag = '0;
    logic [4:0]  specfixtag = '0;
    logic [1:0]  ready = '0;
    logic [0:0]  issueaddr;
    logic        clearbusy;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [5:0]  rrftag;
    logic        dstval;
    logic [4:0]  spectag;
    logic        specbit;
    logic        src1_signed;
    logic        src2_signed;
    logic        sel_lohi;
    logic [31:0] exrslt;
    logic [5:0]  exdst;
    logic        kill_spec;
    logic        rob_we;
    logic        rrf_we;

    // RS entry storage, read combinationally at issueaddr.
    logic [31:0] e_a   [2];
    logic [31:0] e_b   [2];
    logic [5:0]  e_tag [2];
    logic [4:0]  e_st  [2];
    logic        e_dv  [2];
    logic        e_sb  [2];
    logic        e_s1  [2];
    logic        e_s2  [2];
    logic        e_hi  [2];

    assign ex_src1     = e_a[issueaddr];
    assign ex_src2     = e_b[issueaddr];
    assign rrftag      = e_tag[issueaddr];
    assign spectag     = e_st[issueaddr];
    assign dstval      = e_dv[issueaddr];
    assign specbit     = e_sb[issueaddr];
    assign src1_signed = e_s1[issueaddr];
    assign src2_signed = e_s2[issueaddr];
    assign sel_lohi    = e_hi[issueaddr];

    mul_issue_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .prmiss      (prmiss),
        .prsuccess   (prsuccess),
        .prtag       (prtag),
        .specfixtag  (specfixtag),
        .ready       (ready),
        .issueaddr   (issueaddr),
        .clearbusy   (clearbusy),
        .ex_src1     (ex_src1),
        .ex_src2     (ex_src2),
        .rrftag      (rrftag),
        .dstval      (dstval),
        .spectag     (spectag),
        .specbit     (specbit),
        .src1_signed (src1_signed),
        .src2_signed (src2_signed),
        .sel_lohi    (sel_lohi),
        .exrslt      (exrslt),
        .exdst       (exdst),
        .kill_spec   (kill_spec),
        .rob_we      (rob_we),
        .rrf_we      (rrf_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [5:0]  tag;
        logic        dv;
        logic [4:0]  st;
        logic        sb;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic rr_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mref(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sbs, input logic hi);
        logic [65:0] ea;
        logic [65:0] eb;
        logic [65:0] p;
        ea = sa  ? {{34{a[31]}}, a} : {34'd0, a};
        eb = sbs ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Scoreboard: sample just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rob_we) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got rob_we=1 tag=%0d rslt=%h want no completion", exdst, exrslt);
            end else begin
                e = q.pop_front();
                $display("result tag=%0d rslt=%h rrf_we=%b cyc=%0d", exdst, exrslt, rrf_we, cyc);
                if (exrslt !== e.r || exdst !== e.tag || rrf_we !== e.dv || kill_spec !== 1'b0 || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL result: got rslt=%h dst=%0d rrf_we=%b kill=%b cyc=%0d want rslt=%h dst=%0d rrf_we=%b kill=0 cyc=%0d",
                             exrslt, exdst, rrf_we, kill_spec, cyc, e.r, e.tag, e.dv, e.cyc);
                end
            end
        end else begin
            total++;
            if (kill_spec !== 1'b1 || exrslt !== 32'd0 || exdst !== 6'd0 || rrf_we !== 1'b0) begin
                bad++;
                $display("FAIL idle_slot: got kill=%b rslt=%h dst=%0d rrf_we=%b want kill=1 rslt=0 dst=0 rrf_we=0",
                         kill_spec, exrslt, exdst, rrf_we);
            end
            if (q.size() != 0 && q[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_result: got no completion at cyc=%0d want tag=%0d rslt=%h", cyc, q[0].tag, q[0].r);
                void'(q.pop_front());
            end
        end
    end

    task automatic set_entry(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic s1, input logic s2, input logic hi,
                             input logic [5:0] tag, input logic dv,
                             input logic [4:0] st, input logic sb);
        e_a[idx] = a;   e_b[idx] = b;   e_s1[idx] = s1; e_s2[idx] = s2;
        e_hi[idx] = hi; e_tag[idx] = tag; e_dv[idx] = dv; e_st[idx] = st;
        e_sb[idx] = sb;
    endtask

    // Apply one cycle of inputs (caller is at a falling edge) and update the model.
    task automatic apply(input logic [1:0] rdy, input logic pm, input logic ps,
                         input logic [4:0] ptag, input logic [4:0] sfix);
        exp_t keep[$];
        exp_t e;
        logic nx;
        logic p;
        ready = rdy; prmiss = pm; prsuccess = ps; prtag = ptag; specfixtag = sfix;
        if (pm) begin
            foreach (q[i]) if (!(q[i].sb && ((q[i].st & sfix) != 5'd0))) keep.push_back(q[i]);
            q = keep;
        end else if (ps) begin
            foreach (q[i]) if (q[i].st == ptag) q[i].sb = 1'b0;
        end
        if (rdy != 2'b00 && !pm) begin
            nx = ~rr_m;
            p  = rdy[nx] ? nx : rr_m;
            e.r   = mref(e_a[p], e_b[p], e_s1[p], e_s2[p], e_hi[p]);
            e.tag = e_tag[p]; e.dv = e_dv[p]; e.st = e_st[p]; e.sb = e_sb[p];
            e.cyc = cyc + 3;
            q.push_back(e);
            rr_m = p;
            $display("issue entry=%0d tag=%0d cyc=%0d", p, e_tag[p], cyc);
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] rdy, input logic pm, input logic ps,
                         input logic [4:0] ptag, input logic [4:0] sfix);
        @(negedge clk);
        apply(rdy, pm, ps, ptag, sfix);
    endtask

    task automatic issue_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic s1, input logic s2, input logic hi,
                             input logic [5:0] tag, input logic dv,
                             input logic [4:0] st, input logic sb);
        @(negedge clk);
        set_entry(idx, a, b, s1, s2, hi, tag, dv, st, sb);
        apply(2'b01 << idx, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic test_reset;
        @(posedge clk);
        @(posedge clk);
        #2;
        total++; if (exrslt !== 32'd0) begin bad++; $display("FAIL reset_exrslt: got %h want 0", exrslt); end
        total++; if (exdst !== 6'd0) begin bad++; $display("FAIL reset_exdst: got %0d want 0", exdst); end
        total++; if (kill_spec !== 1'b1) begin bad++; $display("FAIL reset_kill_spec: got %b want 1", kill_spec); end
        total++; if (rob_we !== 1'b0) begin bad++; $display("FAIL reset_rob_we: got %b want 0", rob_we); end
        total++; if (rrf_we !== 1'b0) begin bad++; $display("FAIL reset_rrf_we: got %b want 0", rrf_we); end
        total++; if (issueaddr !== 1'b0) begin bad++; $display("FAIL reset_issueaddr: got %0d want 0", issueaddr); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_round_robin;
        logic want;
        set_entry(0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 6'd10, 1'b1, 5'd0, 1'b0);
        set_entry(1, 32'd100, 32'd3, 1'b0, 1'b0, 1'b0, 6'd11, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b0, 1'b0, 5'd0, 5'd0);
            want = (i % 2 == 0) ? 1'b1 : 1'b0;
            total++; if (issueaddr !== want) begin bad++; $display("FAIL rr_issueaddr[%0d]: got %0d want %0d", i, issueaddr, want); end
            total++; if (clearbusy !== 1'b1) begin bad++; $display("FAIL rr_clearbusy[%0d]: got %b want 1", i, clearbusy); end
        end
        // The first result is due now (C+3) and the rest follow back to back.
        total++; if (rob_we !== 1'b1) begin bad++; $display("FAIL b2b_rob_we[0]: got %b want 1", rob_we); end
        for (int j = 1; j < 4; j++) begin
            drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
            total++; if (rob_we !== 1'b1) begin bad++; $display("FAIL b2b_rob_we[%0d]: got %b want 1", j, rob_we); end
        end
    endtask

    task automatic test_signed_lo;
        issue_one(0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 1'b0, 6'd21, 1'b1, 5'd0, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (exrslt !== 32'hFFFFFFF1) begin bad++; $display("FAIL signed_lo_rslt: got %h want fffffff1", exrslt); end
        total++; if (exdst !== 6'd21) begin bad++; $display("FAIL signed_lo_dst: got %0d want 21", exdst); end
        total++; if (rob_we !== 1'b1 || kill_spec !== 1'b0) begin bad++; $display("FAIL signed_lo_valid: got rob_we=%b kill=%b want 1 0", rob_we, kill_spec); end
    endtask

    task automatic test_hi_variants;
        issue_one(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 5'd0, 1'b0);
        issue_one(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 6'd2, 1'b1, 5'd0, 1'b0);
        issue_one(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 6'd3, 1'b1, 5'd0, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (exrslt !== 32'hFFFFFFFE) begin bad++; $display("FAIL uu_hi: got %h want fffffffe", exrslt); end
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (exrslt !== 32'h00000000 || rob_we !== 1'b1) begin bad++; $display("FAIL ss_hi: got %h rob_we=%b want 00000000 1", exrslt, rob_we); end
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (exrslt !== 32'hFFFFFFFF) begin bad++; $display("FAIL su_hi: got %h want ffffffff", exrslt); end
    endtask

    task automatic test_kill;
        issue_one(0, 32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 6'd30, 1'b1, 5'b00010, 1'b1);
        issue_one(1, 32'd17, 32'd19, 1'b0, 1'b0, 1'b0, 6'd31, 1'b1, 5'b01000, 1'b1);
        drive(2'b01, 1'b1, 1'b0, 5'd0, 5'b00110);
        total++; if (clearbusy !== 1'b0) begin bad++; $display("FAIL kill_clearbusy: got %b want 0", clearbusy); end
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (rob_we !== 1'b0) begin bad++; $display("FAIL killed_op: got rob_we=%b dst=%0d want rob_we=0", rob_we, exdst); end
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (rob_we !== 1'b1 || exdst !== 6'd31) begin bad++; $display("FAIL survivor_op: got rob_we=%b dst=%0d want 1 31", rob_we, exdst); end
    endtask

    task automatic test_success;
        issue_one(0, 32'd1234, 32'd5678, 1'b0, 1'b0, 1'b0, 6'd40, 1'b1, 5'b00010, 1'b1);
        drive(2'b00, 1'b0, 1'b1, 5'b00010, 5'd0);
        drive(2'b00, 1'b1, 1'b0, 5'd0, 5'b00010);
        drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++; if (rob_we !== 1'b1 || exdst !== 6'd40 || exrslt !== 32'd7006652) begin
            bad++; $display("FAIL success_survive: got rob_we=%b dst=%0d rslt=%0d want 1 40 7006652", rob_we, exdst, exrslt);
        end
    endtask

    task automatic test_reset_midflight;
        issue_one(0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 6'd50, 1'b1, 5'd0, 1'b0);
        issue_one(1, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0, 6'd51, 1'b1, 5'd0, 1'b0);
        issue_one(0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 6'd52, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ready = 2'b00;
        q.delete();
        rr_m = 1'b0;
        #1;
        total++; if (rob_we !== 1'b0 || kill_spec !== 1'b1 || rrf_we !== 1'b0 || exrslt !== 32'd0 || exdst !== 6'd0) begin
            bad++; $display("FAIL midflight_reset: got rob_we=%b kill=%b rrf_we=%b rslt=%h dst=%0d want 0 1 0 0 0",
                            rob_we, kill_spec, rrf_we, exrslt, exdst);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
            total++; if (rob_we !== 1'b0) begin bad++; $display("FAIL post_reset_rob_we[%0d]: got %b want 0", i, rob_we); end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) set_entry(i, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0, 1'b0);
        test_reset;
        test_round_robin;
        test_signed_lo;
        test_hi_variants;
        test_kill;
        test_success;
        test_reset_midflight;
        for (int i = 0; i < 6; i++) drive(2'b00, 1'b0, 1'b0, 5'd0, 5'd0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding results want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
